// File: rtl/audio_hit_detector_pkg.sv
// Shared audio constants for the microphone hit-detection path.
// Sample/magnitude widths, channel-select encodings and FSM states.
package audio_hit_detector_pkg;

    localparam int SAMPLE_W = 32;
    localparam int MAG_W    = 31;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_AVG   = 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [MAG_W-1:0]           mag_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_PROC
    } state_t;

endpackage

// File: rtl/audio_hit_detector_sample_magnitude.sv
// Combinational channel select / average and saturating absolute value.
// Output is the unsigned 31-bit magnitude of the selected sample.
module sample_magnitude
    import audio_hit_detector_pkg::*;
#(
    parameter int CH_SEL = CH_LEFT
) (
    input  logic signed [SAMPLE_W-1:0] left,
    input  logic signed [SAMPLE_W-1:0] right,
    output logic [MAG_W-1:0]           mag
);

    sample_t          sel;
    logic [SAMPLE_W-1:0] abs_v;

    always_comb begin
        case (CH_SEL)
            CH_RIGHT: sel = right;
            CH_AVG:   sel = (left >>> 1) + (right >>> 1);
            default:  sel = left;
        endcase
    end

    // Only -2^31 leaves bit 31 set after negation; clamp it to full scale.
    always_comb begin
        abs_v = sel[SAMPLE_W-1] ? -sel : sel;
        mag   = abs_v[SAMPLE_W-1] ? '1 : abs_v[MAG_W-1:0];
    end

endmodule

// File: rtl/audio_hit_detector.sv
// Pops ADC samples, tracks per-window peak magnitude and pulses hit
// when a window peak exceeds THRESHOLD, with a holdoff of whole windows.
module audio_hit_detector
    import audio_hit_detector_pkg::*;
#(
    parameter int          WINDOW_LEN  = 1024,
    parameter logic [31:0] THRESHOLD   = 32'd200000000,
    parameter int          HOLDOFF_WIN = 8,
    parameter int          CH_SEL      = 0
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                enable,
    input  logic                audio_in_available,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    output logic                hit,
    output logic [7:0]          level,
    output logic [MAG_W-1:0]    peak,
    output logic                busy_holdoff
);

    localparam int CNT_W = $clog2(WINDOW_LEN);
    localparam int HO_W  = (HOLDOFF_WIN < 1) ? 1 : $clog2(HOLDOFF_WIN + 1);

    state_t           state;
    state_t           state_nxt;
    mag_t             mag;
    mag_t             smp_mag;
    mag_t             run_max;
    mag_t             win_peak;
    logic [CNT_W-1:0] cnt;
    logic [HO_W-1:0]  holdoff;
    logic             win_close;
    logic             over;

    sample_magnitude #(
        .CH_SEL (CH_SEL)
    ) u_mag (
        .left  (left_channel_audio_in),
        .right (right_channel_audio_in),
        .mag   (mag)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable && audio_in_available) state_nxt = S_POP;
            S_POP:   state_nxt = S_PROC;
            S_PROC:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        read_audio_in = (state == S_POP);
    end

    assign win_peak  = (smp_mag > run_max) ? smp_mag : run_max;
    assign win_close = (cnt == CNT_W'(WINDOW_LEN - 1));
    assign over      = ({1'b0, win_peak} > THRESHOLD);

    // An in-flight sample finishes its bookkeeping even if enable drops;
    // the partial window is discarded once the FSM is back in IDLE.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            smp_mag <= '0;
            run_max <= '0;
            cnt     <= '0;
            holdoff <= '0;
            peak    <= '0;
            hit     <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (state == S_POP) smp_mag <= mag;
            if (state == S_PROC) begin
                if (win_close) begin
                    peak    <= win_peak;
                    run_max <= '0;
                    cnt     <= '0;
                    if (holdoff == '0) begin
                        if (over) begin
                            hit     <= 1'b1;
                            holdoff <= HO_W'(HOLDOFF_WIN);
                        end
                    end else begin
                        holdoff <= holdoff - 1'b1;
                    end
                end else begin
                    run_max <= win_peak;
                    cnt     <= cnt + 1'b1;
                end
            end else if (state == S_IDLE && !enable) begin
                run_max <= '0;
                cnt     <= '0;
            end
        end
    end

    assign level        = peak[30:23];
    assign busy_holdoff = (holdoff != '0);

endmodule
